cpu_multicycle: RTL and testbench
=================================

// Module: cpu_multicycle
// PURPOSE
// Parametrised multi-cycle successor of the single-cycle cpu core. Same 32-bit instruction format
// (op[31:28] Rd[27:24] Ra[23:20] Rb[19:16] imm[15:0]). Fetches through a ready-handshaked instruction
// port and loads/stores through a separate data port, so it runs against wait-stated memories.
// Sits between the boot ROM/imem model and the data RAM; exposes halt/retire for the testbench.
// PARAMETERS
// XLEN     32  datapath, PC and register width (16..64)
// NREG     16  architectural registers (8 or 16); index fields wider than log2(NREG) use low bits
// RESET_PC 0   PC value loaded on reset
// PC_STEP  4   PC increment per sequential instruction
// PORTS
// clk          in   1     clock, all state updates on rising edge
// rst          in   1     synchronous, active-high reset
// imem_req     out  1     instruction fetch request
// imem_addr    out  XLEN  fetch address (= PC)
// imem_ready   in   1     fetch complete; imem_rdata valid this cycle
// imem_rdata   in   32    instruction word
// dmem_req     out  1     data access request
// dmem_we      out  1     1 = store, 0 = load
// dmem_addr    out  XLEN  Ra + sext(imm)
// dmem_wdata   out  XLEN  Rb value (stores)
// dmem_ready   in   1     access complete; dmem_rdata valid this cycle (loads)
// dmem_rdata   in   XLEN  load data
// retire       out  1     one-cycle pulse when an instruction commits
// halted       out  1     high in HALT state
// illegal      out  1     sticky; set when an undefined opcode is decoded
// BEHAVIOUR
// - Reset: PC=RESET_PC, state=FETCH, all regs 0, req/we/retire/halted/illegal=0, addr/wdata=0.
//   rst mid-access drops req the next cycle; memory must tolerate a withdrawn request.
// - Opcodes: 0 ADD,1 SUB,2 AND,3 OR,4 XOR (Rd=Ra op Rb); 5 ADDI (Rd=Ra+sext(imm));
//   6 LW (Rd=mem[Ra+sext]); 7 SW (mem[Ra+sext]=Rb); 8 BEQ (Ra==Rb: PC+=sext(imm));
//   9 JAL (Rd=PC+PC_STEP, PC+=sext(imm)); A LUI (Rd=imm<<16, zero-filled); F HALT; B-E illegal.
// - r0 reads 0; writes to r0 discarded. Arithmetic modulo 2^XLEN; imm sign-extended to XLEN;
//   branch/jump offsets in bytes relative to PC of the branch itself.
// - FSM: FETCH -> DECODE -> EXEC -> {WB | MEM | FETCH}; MEM -> {WB | FETCH}; WB -> FETCH; HALT terminal.
//   FETCH: imem_req=1, imem_addr=PC held stable until imem_ready; on ready latch IR -> DECODE.
//   DECODE: latch A=R[Ra], B=R[Rb]; HALT op -> HALT; illegal op -> set illegal, -> HALT.
//   EXEC: compute result/next PC. BEQ: PC<=taken?PC+sext:PC+PC_STEP, retire, -> FETCH.
//         LW/SW -> MEM; ALU/ADDI/LUI/JAL -> WB.
//   MEM: dmem_req=1, addr/we/wdata stable until dmem_ready. LW: latch rdata -> WB.
//        SW: write completes on ready, PC+=PC_STEP, retire, -> FETCH.
//   WB: write Rd, PC<=next PC, retire=1, -> FETCH.
// - Latency, zero-wait memory: ALU/JAL 4 cycles, BEQ 3, LW 5, SW 4; each wait cycle adds 1.
// - req deasserts the cycle after ready; no back-to-back request without passing through FETCH.
// - HALT: req=0, halted=1, PC frozen; exit only via rst.
// STRUCTURE
// - cpu_defs.vh: opcode localparams, FSM state encodings, ALU op codes.
// - Sub-module cpu_regfile: NREG x XLEN, 2 async read, 1 sync write, r0 hardwired zero.
// - Top holds PC, IR, A/B/MDR latches, FSM, ALU and sign-extend inline.
// TESTING
// - ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT, zero-wait -> r3=12, 3 retires, halted, cycle counts 4/4/4.
// - BEQ r1,r1,+8 at PC=0x10 -> next fetch 0x18; BEQ r1,r2 (unequal) -> next fetch 0x14.
// - SW r2,4(r1) then LW r4,4(r1), dmem_ready delayed 3 cycles -> dmem_addr=0x9 held stable, r4=7.
// - JAL r5,-4 at PC=0x20 -> r5=0x24, next fetch 0x1C; ADDI r0,r0,9 -> r0 stays 0.
// - Opcode 0xC -> illegal=1, halted=1, no retire; rst asserted during a waited fetch -> imem_req=0 next
//   cycle, PC=RESET_PC, regs 0.
// - XLEN=16: ADDI r1,r0,-1; ADDI r1,r1,1 -> r1=0x0000 (wrap).

Source files
------------

// File: rtl/cpu_multicycle_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, decode helper.
package cpu_multicycle_pkg;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLw   = 4'h6;
  localparam logic [3:0] OpSw   = 4'h7;
  localparam logic [3:0] OpBeq  = 4'h8;
  localparam logic [3:0] OpJal  = 4'h9;
  localparam logic [3:0] OpLui  = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  // Opcodes 0xB..0xE are unassigned.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_multicycle_regfile.sv
// Register file: NREG x XLEN, two asynchronous reads, one synchronous write, r0 reads zero.
module cpu_multicycle_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 16,
  parameter int unsigned RegAw = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RegAw-1:0] raddr_a_i,
  output logic [XLEN-1:0]  rdata_a_o,
  input  logic [RegAw-1:0] raddr_b_i,
  output logic [XLEN-1:0]  rdata_b_o,
  input  logic             we_i,
  input  logic [RegAw-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  // Storage: cleared on reset, writes to r0 dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: r0 forced to zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB over ready-handshaked instruction and data ports.
module cpu_multicycle
  import cpu_multicycle_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ready_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            retire_o,
  output logic            halted_o,
  output logic            illegal_o
);

  localparam int unsigned RegAw = $clog2(NREG);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d, mdr_q, mdr_d;
  logic            illegal_q, illegal_d;
  logic            imem_req, dmem_req, retire, rf_we;

  logic [3:0]       op;
  logic [RegAw-1:0] rd, ra, rb;
  logic [15:0]      imm;
  logic [XLEN-1:0]  imm_sext, lui_val, pc_inc, rf_a, rf_b, rf_wdata;

  assign op       = ir_q[31:28];
  assign rd       = ir_q[24 +: RegAw];
  assign ra       = ir_q[20 +: RegAw];
  assign rb       = ir_q[16 +: RegAw];
  assign imm      = ir_q[15:0];
  assign imm_sext = XLEN'($signed(imm));
  assign lui_val  = XLEN'({imm, 16'h0000});
  assign pc_inc   = pc_q + XLEN'(PC_STEP);
  assign rf_wdata = (op == OpLw) ? mdr_q : res_q;

  cpu_multicycle_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raddr_a_i (ra),
    .rdata_a_o (rf_a),
    .raddr_b_i (rb),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata)
  );

  // Next-state, datapath latches and handshake outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    retire    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready_i) begin
          ir_d    = imem_rdata_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = rf_a;
        b_d = rf_b;
        if (op == OpHalt) begin
          state_d = StHalt;
        end else if (is_illegal(op)) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        npc_d   = pc_inc;
        state_d = StWb;
        case (op)
          OpAdd:  res_d = a_q + b_q;
          OpSub:  res_d = a_q - b_q;
          OpAnd:  res_d = a_q & b_q;
          OpOr:   res_d = a_q | b_q;
          OpXor:  res_d = a_q ^ b_q;
          OpAddi: res_d = a_q + imm_sext;
          OpLui:  res_d = lui_val;
          OpLw, OpSw: begin
            res_d   = a_q + imm_sext;
            state_d = StMem;
          end
          OpBeq: begin
            pc_d    = (a_q == b_q) ? pc_q + imm_sext : pc_inc;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJal: begin
            res_d = pc_inc;
            npc_d = pc_q + imm_sext;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        if (dmem_ready_i) begin
          if (op == OpLw) begin
            mdr_d   = dmem_rdata_i;
            state_d = StWb;
          end else begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_d    = npc_q;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  // Architectural and pipeline-latch state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      npc_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

  // Requests and retire are withheld while reset is held so a reset mid-access withdraws them.
  always_comb begin
    imem_req_o   = imem_req & ~rst_i;
    dmem_req_o   = dmem_req & ~rst_i;
    retire_o     = retire & ~rst_i;
    imem_addr_o  = pc_q;
    dmem_we_o    = (state_q == StMem) && (op == OpSw);
    dmem_addr_o  = res_q;
    dmem_wdata_o = b_q;
    halted_o     = (state_q == StHalt);
    illegal_o    = illegal_q;
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle with wait-stated instruction/data memory models.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  logic        imem16_req, dmem16_req, dmem16_we, retire16, halted16, illegal16;
  logic [15:0] imem16_addr, dmem16_addr, dmem16_wdata;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] imem16 [16];
  int          imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;

  int          n_checks = 0, n_pass = 0;
  int          retq[$];
  logic [31:0] fetchq[$];
  logic [31:0] exp_daddr = 32'h0;
  int          dmem_seen = 0, daddr_bad = 0, we_cycles = 0;

  always #5 clk = ~clk;

  cpu_multicycle dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_ready_i (dmem_ready),
    .dmem_rdata_i (dmem_rdata),
    .retire_o     (retire),
    .halted_o     (halted),
    .illegal_o    (illegal)
  );

  cpu_multicycle #(
    .XLEN     (16),
    .RESET_PC (16'h0000)
  ) dut16 (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem16_req),
    .imem_addr_o  (imem16_addr),
    .imem_ready_i (imem16_req),
    .imem_rdata_i (imem16[imem16_addr[5:2]]),
    .dmem_req_o   (dmem16_req),
    .dmem_we_o    (dmem16_we),
    .dmem_addr_o  (dmem16_addr),
    .dmem_wdata_o (dmem16_wdata),
    .dmem_ready_i (1'b1),
    .dmem_rdata_i (16'h0000),
    .retire_o     (retire16),
    .halted_o     (halted16),
    .illegal_o    (illegal16)
  );

  // Memory models: ready after imem_wait/dmem_wait stalled cycles.
  assign imem_ready = imem_req && (icnt == imem_wait);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt == dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[5:0]];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [15:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hF000_0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the first FETCH cycle after reset release.
  task automatic run(input int max_cyc);
    retq.delete();
    fetchq.delete();
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) fetchq.push_back(imem_addr);
      if (retire) retq.push_back(i);
      if (dmem_req) begin
        dmem_seen++;
        if (dmem_addr !== exp_daddr) daddr_bad++;
        if (dmem_we) we_cycles++;
      end
      if (halted) return;
    end
    check("run_reached_halt", halted, 1);
  endtask

  function automatic logic [31:0] rq(input int i);
    return (i < retq.size()) ? retq[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] fq(input int i);
    return (i < fetchq.size()) ? fetchq[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_imem();
    for (int i = 0; i < 16; i++) imem16[i] = 32'hF000_0000;
    imem16[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'hFFFF);
    imem16[1] = enc(4'h5, 4'd1, 4'd1, 4'd0, 16'h0001);

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);

    // ADDI/ADDI/ADD/HALT, zero wait.
    imem[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'd5);
    imem[1] = enc(4'h5, 4'd2, 4'd0, 4'd0, 16'd7);
    imem[2] = enc(4'h0, 4'd3, 4'd1, 4'd2, 16'd0);
    do_reset();
    run(100);
    check("alu_r3", dut.u_regfile.regs_q[3], 12);
    check("alu_retires", retq.size(), 3);
    check("alu_lat0", rq(0) + 1, 4);
    check("alu_lat1", rq(1) - rq(0), 4);
    check("alu_lat2", rq(2) - rq(1), 4);
    check("alu_fetch2", fq(2), 32'h8);
    check("alu_halted", halted, 1);
    repeat (3) @(negedge clk);
    check("halt_req", imem_req, 0);
    check("halt_pc_frozen", imem_addr, 32'hC);

    // BEQ taken at 0x10.
    clear_imem();
    imem[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'd3);
    imem[1] = enc(4'h5, 4'd2, 4'd0, 4'd0, 16'd4);
    imem[2] = 32'h0;
    imem[3] = 32'h0;
    imem[4] = enc(4'h8, 4'd0, 4'd1, 4'd1, 16'd8);
    do_reset();
    run(100);
    check("beq_taken_fetch", fq(5), 32'h18);
    check("beq_latency", rq(4) - rq(3), 3);
    check("beq_taken_pc", imem_addr, 32'h18);

    // BEQ not taken.
    imem[4] = enc(4'h8, 4'd0, 4'd1, 4'd2, 16'd8);
    do_reset();
    run(100);
    check("beq_nt_fetch", fq(5), 32'h14);

    // SW then LW with three data wait cycles.
    clear_imem();
    imem[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'd5);
    imem[1] = enc(4'h5, 4'd2, 4'd0, 4'd0, 16'd7);
    imem[2] = enc(4'h7, 4'd0, 4'd1, 4'd2, 16'd4);
    imem[3] = enc(4'h6, 4'd4, 4'd1, 4'd0, 16'd4);
    dmem_wait = 3;
    exp_daddr = 32'h9;
    dmem_seen = 0;
    daddr_bad = 0;
    we_cycles = 0;
    do_reset();
    run(100);
    check("mem_addr_stable", daddr_bad, 0);
    check("mem_req_cycles", dmem_seen, 8);
    check("mem_we_cycles", we_cycles, 4);
    check("mem_stored", dmem[9], 7);
    check("mem_r4", dut.u_regfile.regs_q[4], 7);
    check("sw_latency", rq(2) - rq(1), 7);
    check("lw_latency", rq(3) - rq(2), 8);
    dmem_wait = 0;

    // JAL backwards, write to r0 discarded.
    clear_imem();
    imem[0] = enc(4'h5, 4'd0, 4'd0, 4'd0, 16'd9);
    imem[1] = enc(4'h9, 4'd6, 4'd0, 4'd0, 16'h001C);
    imem[8] = enc(4'h9, 4'd5, 4'd0, 4'd0, 16'hFFFC);
    do_reset();
    run(100);
    check("jal_r5", dut.u_regfile.regs_q[5], 32'h24);
    check("jal_r6", dut.u_regfile.regs_q[6], 32'h8);
    check("jal_fetch_fwd", fq(2), 32'h20);
    check("jal_fetch_back", fq(3), 32'h1C);
    check("r0_zero", dut.u_regfile.regs_q[0], 0);

    // Illegal opcode.
    clear_imem();
    imem[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'd1);
    imem[1] = 32'hC000_0000;
    do_reset();
    check("illegal_clear", illegal, 0);
    run(100);
    check("illegal_set", illegal, 1);
    check("illegal_halted", halted, 1);
    check("illegal_retires", retq.size(), 1);
    check("illegal_r1", dut.u_regfile.regs_q[1], 1);

    // Reset during a waited fetch.
    clear_imem();
    imem[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 16'd5);
    do_reset();
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!retire && k < 20);
    end
    imem_wait = 6;
    repeat (2) @(negedge clk);
    check("wait_fetch_req", imem_req, 1);
    check("wait_fetch_addr", imem_addr, 32'h4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_pc", imem_addr, 0);
    check("midrst_r1", dut.u_regfile.regs_q[1], 0);
    imem_wait = 0;

    // XLEN=16 wrap, run alongside a final reset.
    do_reset();
    repeat (30) @(negedge clk);
    check("x16_halted", halted16, 1);
    check("x16_r1_wrap", dut16.u_regfile.regs_q[1], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
